// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex display scanner with a double-buffered display image.
// A prescaler (cnt) and digit index (idx) walk through NUM_DIG slots of DIV cycles each.
// Loaded data waits in a pending buffer and is promoted to the active buffer on a frame wrap.
module seg_scan_driver #(
    parameter int unsigned NUM_DIG = 8,
    parameter int unsigned DIV     = 1000,
    parameter int unsigned GUARD   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [4*NUM_DIG-1:0]   data,
    input  logic [NUM_DIG-1:0]     dp_in,
    input  logic [NUM_DIG-1:0]     blank_mask,
    output logic                   pending,
    output logic [7:0]             seg_out,
    output logic [NUM_DIG-1:0]     dig_sel,
    output logic                   frame_tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IdxW = $clog2(NUM_DIG);
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIG - 1);
    localparam logic [CntW-1:0] GuardC = CntW'(GUARD);

    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic                   tick_q, tick_d;
    logic                   pend_q, pend_d;
    logic [7:0]             seg_q, seg_d;
    logic [NUM_DIG-1:0]     dig_q, dig_d;
    logic [4*NUM_DIG-1:0]   pdata_q, pdata_d, adata_q, adata_d;
    logic [NUM_DIG-1:0]     pdp_q, pdp_d, adp_q, adp_d;
    logic [NUM_DIG-1:0]     pblank_q, pblank_d, ablank_q, ablank_d;
    logic                   cnt_wrap, frame_wrap;
    logic [3:0]             nib;
    logic                   dp_sel, blank_sel;
    logic [NUM_DIG-1:0]     one_hot;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Prescaler and digit index; frame_tick flags the edge that wraps both.
    always_comb begin
        cnt_wrap   = (cnt_q == CntMax);
        frame_wrap = cnt_wrap && (idx_q == IdxMax);
        cnt_d      = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
        end
        tick_d = frame_wrap;
    end

    // Double buffer: a load on the wrap edge bypasses straight into the active image.
    always_comb begin
        pdata_d  = pdata_q;
        pdp_d    = pdp_q;
        pblank_d = pblank_q;
        adata_d  = adata_q;
        adp_d    = adp_q;
        ablank_d = ablank_q;
        pend_d   = pend_q;
        if (load) begin
            pdata_d  = data;
            pdp_d    = dp_in;
            pblank_d = blank_mask;
            pend_d   = 1'b1;
        end
        if (frame_wrap) begin
            pend_d = 1'b0;
            if (load) begin
                adata_d  = data;
                adp_d    = dp_in;
                ablank_d = blank_mask;
            end else if (pend_q) begin
                adata_d  = pdata_q;
                adp_d    = pdp_q;
                ablank_d = pblank_q;
            end
        end
    end

    // Key-select of the current digit's nibble/dp/blank, then decode to registered outputs.
    always_comb begin
        nib       = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        one_hot   = '0;
        for (int unsigned k = 0; k < NUM_DIG; k++) begin
            if (idx_q == IdxW'(k)) begin
                nib        = adata_q[4*k +: 4];
                dp_sel     = adp_q[k];
                blank_sel  = ablank_q[k];
                one_hot[k] = 1'b1;
            end
        end
        if ((cnt_q < GuardC) || blank_sel) begin
            dig_d = '1;
            seg_d = 8'hFF;
        end else begin
            dig_d = ~one_hot;
            seg_d = ~{dp_sel, hex7(nib)};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            tick_q   <= 1'b0;
            pend_q   <= 1'b0;
            seg_q    <= 8'hFF;
            dig_q    <= '1;
            pdata_q  <= '0;
            pdp_q    <= '0;
            pblank_q <= '0;
            adata_q  <= '0;
            adp_q    <= '0;
            ablank_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            tick_q   <= tick_d;
            pend_q   <= pend_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            pdata_q  <= pdata_d;
            pdp_q    <= pdp_d;
            pblank_q <= pblank_d;
            adata_q  <= adata_d;
            adp_q    <= adp_d;
            ablank_q <= ablank_d;
        end
    end

    assign pending    = pend_q;
    assign seg_out    = seg_q;
    assign dig_sel    = dig_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: small configuration (4 digits, DIV=4, GUARD=1)
// plus a second instance (DIV=7, GUARD=3) driven by random loads against a scoreboard.
module tb_seg_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance 1: NUM_DIG=4, DIV=4, GUARD=1
    logic        rst_n, load, pending, frame_tick;
    logic [15:0] data;
    logic [3:0]  dp_in, blank_mask, dig_sel;
    logic [7:0]  seg_out;

    // Instance 2: NUM_DIG=4, DIV=7, GUARD=3
    logic        rst2_n, load2, pending2, frame_tick2;
    logic [15:0] data2;
    logic [3:0]  dp2, blank2, dig_sel2;
    logic [7:0]  seg_out2;

    seg_scan_driver #(.NUM_DIG(4), .DIV(4), .GUARD(1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in),
        .blank_mask(blank_mask), .pending(pending), .seg_out(seg_out),
        .dig_sel(dig_sel), .frame_tick(frame_tick)
    );

    seg_scan_driver #(.NUM_DIG(4), .DIV(7), .GUARD(3)) dut2 (
        .clk(clk), .rst_n(rst2_n), .load(load2), .data(data2), .dp_in(dp2),
        .blank_mask(blank2), .pending(pending2), .seg_out(seg_out2),
        .dig_sel(dig_sel2), .frame_tick(frame_tick2)
    );

    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Expected {dig_sel, seg_out} for slot s, cycle c within the slot.
    function automatic logic [11:0] exp_out(input int c, input int s, input int guard,
                                            input logic [15:0] d, input logic [3:0] dp,
                                            input logic [3:0] bl);
        logic [3:0] nib;
        logic [3:0] dg;
        nib = d[4*s +: 4];
        dg  = ~(4'b0001 << s);
        if (c < guard || bl[s]) exp_out = {4'hF, 8'hFF};
        else                    exp_out = {dg, ~{dp[s], hex_tbl[nib]}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_tick !== 1'b1 && n < 40);
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL %s: frame_tick not seen within 40 cycles", name);
        end
    endtask

    // Called at the cycle frame_tick is high; walks the whole 16-cycle frame.
    task automatic check_frame(input string name, input logic [15:0] d,
                               input logic [3:0] dp, input logic [3:0] bl);
        logic [11:0] e;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                e = exp_out(c, s, 1, d, dp, bl);
                checks++;
                if ({dig_sel, seg_out} !== e) begin
                    errors++;
                    $display("FAIL %s slot%0d cyc%0d: dig_sel=%b seg_out=%h, want %b %h",
                             name, s, c, dig_sel, seg_out, e[11:8], e[7:0]);
                end
            end
        end
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL %s period: frame_tick=%b after 16 cycles, want 1", name, frame_tick);
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (2) tick();
        rst_n = 1'b1;
        data  = 16'h1234;
        load  = 1'b1;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if ({pending, dig_sel, seg_out} !== {1'b1, 4'b1110, 8'hC0}) begin
            errors++;
            $display("FAIL reset_pre: pending=%b dig_sel=%b seg_out=%h, want 1 1110 c0",
                     pending, dig_sel, seg_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (seg_out !== 8'hFF) begin
            errors++;
            $display("FAIL reset_seg: seg_out=%h, want ff", seg_out);
        end
        checks++;
        if (dig_sel !== 4'hF) begin
            errors++;
            $display("FAIL reset_dig: dig_sel=%h, want f", dig_sel);
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending: pending=%b, want 0", pending);
        end
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick: frame_tick=%b, want 0", frame_tick);
        end
        tick();
        rst_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_tick !== 1'b1 && n < 40);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL reset_first_tick: first frame_tick after %0d cycles, want 16", n);
        end
    endtask

    task automatic test_load_first();
        data = 16'h3210; dp_in = 4'h0; blank_mask = 4'h0; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL load_pending: pending=%b, want 1", pending);
        end
        wait_frame("load_first");
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL load_promote: pending=%b, want 0", pending);
        end
        check_frame("load_3210", 16'h3210, 4'h0, 4'h0);
    endtask

    task automatic test_mid_frame();
        int n;
        repeat (5) tick();
        data = 16'h1111; load = 1'b1;
        tick();
        data = 16'hFFFF;
        tick();
        load = 1'b0;
        n = 0;
        while (frame_tick !== 1'b1 && n < 40) begin
            checks++;
            if (pending !== 1'b1 || seg_out === 8'h8E) begin
                errors++;
                $display("FAIL mid_hold: pending=%b seg_out=%h, want 1 and old digits",
                         pending, seg_out);
            end
            tick();
            n++;
        end
        checks++;
        if (frame_tick !== 1'b1 || pending !== 1'b0) begin
            errors++;
            $display("FAIL mid_swap: frame_tick=%b pending=%b, want 1 0", frame_tick, pending);
        end
        check_frame("mid_ffff", 16'hFFFF, 4'h0, 4'h0);
    endtask

    task automatic test_wrap_load();
        repeat (15) tick();
        data = 16'h8888; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if ({frame_tick, pending} !== 2'b10) begin
            errors++;
            $display("FAIL wrap_load: frame_tick=%b pending=%b, want 1 0", frame_tick, pending);
        end
        check_frame("wrap_8888", 16'h8888, 4'h0, 4'h0);
    endtask

    task automatic test_blank_dp();
        data = 16'h0000; dp_in = 4'b0001; blank_mask = 4'b0010; load = 1'b1;
        tick();
        load = 1'b0;
        wait_frame("blank_dp");
        check_frame("blank_dp", 16'h0000, 4'b0001, 4'b0010);
    endtask

    task automatic test_scoreboard();
        int pc, ps, frames;
        logic ld, wrap, pm;
        logic [15:0] sh_d, la_d;
        logic [3:0]  sh_dp, sh_bl, la_dp, la_bl;
        logic [11:0] e;
        pc = 0; ps = 0; frames = 0; pm = 1'b0;
        sh_d = '0; sh_dp = '0; sh_bl = '0; la_d = '0; la_dp = '0; la_bl = '0;
        rst2_n = 1'b1;
        for (int i = 0; i < 28000; i++) begin
            ld = ($urandom_range(0, 15) == 0);
            if (ld) begin
                data2  = 16'($urandom);
                dp2    = 4'($urandom);
                blank2 = 4'($urandom);
            end
            load2 = ld;
            tick();
            wrap = (pc == 6 && ps == 3);
            if (ld) begin
                la_d = data2; la_dp = dp2; la_bl = blank2;
            end
            e = exp_out(pc, ps, 3, sh_d, sh_dp, sh_bl);
            checks++;
            if ({dig_sel2, seg_out2} !== e || $countones(~dig_sel2) > 1) begin
                errors++;
                $display("FAIL sb_out cyc%0d: dig_sel=%b seg_out=%h, want %b %h",
                         i, dig_sel2, seg_out2, e[11:8], e[7:0]);
            end
            checks++;
            if (frame_tick2 !== wrap) begin
                errors++;
                $display("FAIL sb_tick cyc%0d: frame_tick=%b, want %b", i, frame_tick2, wrap);
            end
            if (wrap)    pm = 1'b0;
            else if (ld) pm = 1'b1;
            checks++;
            if (pending2 !== pm) begin
                errors++;
                $display("FAIL sb_pending cyc%0d: pending=%b, want %b", i, pending2, pm);
            end
            if (wrap) begin
                sh_d = la_d; sh_dp = la_dp; sh_bl = la_bl;
                frames++;
            end
            if (pc == 6) begin
                pc = 0;
                ps = (ps + 1) % 4;
            end else begin
                pc++;
            end
        end
        load2 = 1'b0;
        checks++;
        if (frames != 1000) begin
            errors++;
            $display("FAIL sb_frames: %0d frames, want 1000", frames);
        end
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; data = '0; dp_in = '0; blank_mask = '0;
        rst2_n = 1'b0; load2 = 1'b0; data2 = '0; dp2 = '0; blank2 = '0;
        test_reset();
        test_load_first();
        test_mid_frame();
        test_wrap_load();
        test_blank_dp();
        test_scoreboard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
